fft_last_ctrl: RTL and testbench

- Sequencing controller for the last two stages of the R2SDF FFT pipeline:
  - the delay-2 stage and the trivial-twiddle rotator (W = 1 or -j), driven via `phi`;
  - the delay-1 final butterfly stage.
- Counts accepted samples per frame and generates the butterfly-select and twiddle-select strobes.
- Tracks in-flight samples so it can flag output valid, start of frame and end of frame.
- Self-flushes the 3-sample pipeline tail when input goes quiet after a frame.

---
 rtl/fft_pkg.sv | 16 +
 rtl/fft_tok_pipe.sv | 48 ++++
 rtl/fft_last_ctrl.sv | 139 +++++++++++++
 tb/tb_fft_last_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared types for the last-two-stage R2SDF FFT sequencer: FSM states and
// the {real, idx} token that tracks samples through the 3-push pipeline tail.
package fft_pkg;

  typedef enum logic [1:0] {IDLE, RUN, TAIL, FLUSH} state_e;

  localparam int PIPE_LAT  = 3;
  // Fixed token index width so the type is shared; LOG2N must not exceed it.
  localparam int TOK_IDX_W = 16;

  typedef struct packed {
    logic                 is_real;
    logic [TOK_IDX_W-1:0] idx;
  } tok_t;

endpackage

// File: rtl/fft_tok_pipe.sv
// Push-gated token shift register mirroring the datapath tail; the token
// leaving on each push is decoded into registered out_valid/out_sop/out_eop.
module fft_tok_pipe
  import fft_pkg::*;
#(
  parameter int LOG2N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             real_i,
  input  logic [LOG2N-1:0] idx_i,
  output logic             out_valid_o,
  output logic             out_sop_o,
  output logic             out_eop_o,
  output logic             inflight_d_o
);

  localparam int N = 1 << LOG2N;

  tok_t [PIPE_LAT-1:0] pipe_q, pipe_d;
  tok_t                new_tok, old_tok;

  always_comb begin
    new_tok.is_real = real_i;
    new_tok.idx     = real_i ? TOK_IDX_W'(idx_i) : '0;
    old_tok         = pipe_q[PIPE_LAT-1];
    pipe_d          = pipe_q;
    if (push_i) pipe_d = {pipe_q[PIPE_LAT-2:0], new_tok};
    inflight_d_o = 1'b0;
    for (int i = 0; i < PIPE_LAT; i++) inflight_d_o = inflight_d_o | pipe_d[i].is_real;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_q      <= '0;
      out_valid_o <= 1'b0;
      out_sop_o   <= 1'b0;
      out_eop_o   <= 1'b0;
    end else begin
      pipe_q      <= pipe_d;
      out_valid_o <= push_i & old_tok.is_real;
      out_sop_o   <= push_i & old_tok.is_real & (old_tok.idx == '0);
      out_eop_o   <= push_i & old_tok.is_real & (old_tok.idx == TOK_IDX_W'(N-1));
    end
  end

endmodule

// File: rtl/fft_last_ctrl.sv
// Sequencer for the delay-2/rotator and delay-1 stages of the R2SDF FFT.
// Optional FFT_LAST_CTRL_FRAME_CNT_EN adds a 16-bit completed-frame counter.
module fft_last_ctrl
  import fft_pkg::*;
#(
  parameter int LOG2N     = 4,
  parameter int FLUSH_GAP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        in_sop,
  output logic        push,
  output logic        bf_sel2,
  output logic        phi,
  output logic        bf_sel1,
  output logic        out_valid,
  output logic        out_sop,
  output logic        out_eop,
  output logic        sop_err,
`ifdef FFT_LAST_CTRL_FRAME_CNT_EN
  output logic [15:0] frame_cnt,
`endif
  output logic        busy
);

  localparam int N     = 1 << LOG2N;
  localparam int GAP_W = $clog2(FLUSH_GAP + 1);

  state_e             state_q, state_d;
  logic [LOG2N-1:0]   k_q, k_d, k_eff;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               accept, syn, push_d, inflight_d;
  logic               push_q, bf_sel2_q, phi_q, bf_sel1_q, sop_err_q, busy_q;
  logic               bf_sel2_d, phi_d, bf_sel1_d, sop_err_d, busy_d;

  assign accept = in_valid & (in_sop | (state_q == RUN));
  // A real sop sample in FLUSH takes the slot of that cycle's synthetic push.
  assign syn    = (state_q == FLUSH) & ~accept;
  assign push_d = accept | syn;
  assign k_eff  = (accept & in_sop) ? '0 : k_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    gap_d   = gap_q;
    if (accept) begin
      k_d = k_eff + LOG2N'(1);
      if (k_eff == LOG2N'(N-1)) begin
        state_d = TAIL;
        gap_d   = '0;
      end else begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        TAIL: begin
          gap_d = gap_q + GAP_W'(1);
          if (gap_q == GAP_W'(FLUSH_GAP-1)) state_d = FLUSH;
        end
        FLUSH: begin
          k_d = k_q + LOG2N'(1);
          if (k_q == LOG2N'(PIPE_LAT-1)) begin
            state_d = IDLE;
            k_d     = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bf_sel2_d = push_d & k_eff[1];
    bf_sel1_d = push_d & k_eff[0];
    phi_d     = push_d & k_eff[1] & k_eff[0];
    sop_err_d = accept & in_sop & (state_q == RUN) & (k_q != '0);
    busy_d    = (state_d != IDLE) | inflight_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      push_q    <= 1'b0;
      bf_sel2_q <= 1'b0;
      phi_q     <= 1'b0;
      bf_sel1_q <= 1'b0;
      sop_err_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      push_q    <= push_d;
      bf_sel2_q <= bf_sel2_d;
      phi_q     <= phi_d;
      bf_sel1_q <= bf_sel1_d;
      sop_err_q <= sop_err_d;
      busy_q    <= busy_d;
    end
  end

  assign push    = push_q;
  assign bf_sel2 = bf_sel2_q;
  assign phi     = phi_q;
  assign bf_sel1 = bf_sel1_q;
  assign sop_err = sop_err_q;
  assign busy    = busy_q;

  fft_tok_pipe #(.LOG2N(LOG2N)) u_tok_pipe (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push_d),
    .real_i       (accept),
    .idx_i        (k_eff),
    .out_valid_o  (out_valid),
    .out_sop_o    (out_sop),
    .out_eop_o    (out_eop),
    .inflight_d_o (inflight_d)
  );

`ifdef FFT_LAST_CTRL_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
  always_ff @(posedge clk) begin
    if (rst)          frame_cnt_q <= '0;
    else if (out_eop) frame_cnt_q <= frame_cnt_q + 16'd1;
  end
  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_fft_last_ctrl.sv
// Directed bench for fft_last_ctrl (N = 16, FLUSH_GAP = 8).
module tb_fft_last_ctrl;

  logic clk = 1'b0;
  logic rst, in_valid, in_sop;
  logic push, bf_sel2, phi, bf_sel1, out_valid, out_sop, out_eop, sop_err, busy;
`ifdef FFT_LAST_CTRL_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int err_n = 0;
  int chk_n = 0;

  always #5 clk = ~clk;

  fft_last_ctrl #(.LOG2N(4), .FLUSH_GAP(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sop    (in_sop),
    .push      (push),
    .bf_sel2   (bf_sel2),
    .phi       (phi),
    .bf_sel1   (bf_sel1),
    .out_valid (out_valid),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .sop_err   (sop_err),
`ifdef FFT_LAST_CTRL_FRAME_CNT_EN
    .frame_cnt (frame_cnt),
`endif
    .busy      (busy)
  );

  // {push, bf_sel2, bf_sel1, phi, out_valid, out_sop, out_eop, sop_err, busy}
  logic [8:0] obs;
  assign obs = {push, bf_sel2, bf_sel1, phi, out_valid, out_sop, out_eop, sop_err, busy};

  task automatic step(input logic v, input logic s, input logic r);
    in_valid = v; in_sop = s; rst = r;
    @(posedge clk); #1;
  endtask

  // Expected vector for a real sample with index k and given token decode.
  function automatic logic [8:0] ctl(input int k, input logic ov, input logic os,
                                     input logic oe, input logic se);
    logic [3:0] kb;
    kb = k[3:0];
    return {1'b1, kb[1], kb[0], kb[1] & kb[0], ov, os, oe, se, 1'b1};
  endfunction

  // After the last sample of a frame: 8 quiet cycles, then 3 synthetic pushes
  // emitting idx 13, 14, 15, then back to idle.
  task automatic drain_tail(input string tag);
    logic [8:0] exp;
    for (int g = 0; g < 8; g++) begin
      step(1'b0, 1'b0, 1'b0);
      exp = 9'b0_0000_0001;
      chk_n++;
      if (obs !== exp) begin err_n++; $display("FAIL %s gap%0d obs=%b exp=%b", tag, g, obs, exp); end
    end
    for (int f = 0; f < 3; f++) begin
      step(1'b0, 1'b0, 1'b0);
      exp = {1'b1, f == 2, f == 1, 1'b0, 1'b1, 1'b0, f == 2, 1'b0, f != 2};
      chk_n++;
      if (obs !== exp) begin err_n++; $display("FAIL %s flush%0d obs=%b exp=%b", tag, f, obs, exp); end
    end
    step(1'b0, 1'b0, 1'b0);
    chk_n++;
    if (obs !== 9'b0) begin err_n++; $display("FAIL %s idle obs=%b exp=%b", tag, obs, 9'b0); end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 1'b1, 1'b1);
      chk_n++;
      if (obs !== 9'b0) begin err_n++; $display("FAIL reset obs=%b exp=%b", obs, 9'b0); end
    end
  endtask

  task automatic test_single_frame();
    logic [8:0] exp;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, k == 0, 1'b0);
      exp = ctl(k, k >= 3, k == 3, 1'b0, 1'b0);
      chk_n++;
      if (obs !== exp) begin err_n++; $display("FAIL single k=%0d obs=%b exp=%b", k, obs, exp); end
    end
    drain_tail("single");
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp;
    for (int i = 0; i < 32; i++) begin
      step(1'b1, (i % 16) == 0, 1'b0);
      exp = ctl(i % 16, i >= 3, (i == 3) || (i == 19), i == 18, 1'b0);
      chk_n++;
      if (obs !== exp) begin err_n++; $display("FAIL b2b i=%0d obs=%b exp=%b", i, obs, exp); end
    end
    drain_tail("b2b");
  endtask

  task automatic test_gapped();
    logic [8:0] exp;
    int nval;
    nval = 0;
    for (int k = 0; k < 16; k++) begin
      step(1'b1, k == 0, 1'b0);
      nval += int'(out_valid);
      exp = ctl(k, k >= 3, k == 3, 1'b0, 1'b0);
      chk_n++;
      if (obs !== exp) begin err_n++; $display("FAIL gapped k=%0d obs=%b exp=%b", k, obs, exp); end
      if (k < 15) begin
        step(1'b0, 1'b0, 1'b0);
        nval += int'(out_valid);
        exp = 9'b0_0000_0001;
        chk_n++;
        if (obs !== exp) begin err_n++; $display("FAIL gapped hole k=%0d obs=%b exp=%b", k, obs, exp); end
      end
    end
    chk_n++;
    if (nval !== 13) begin err_n++; $display("FAIL gapped valid_count obs=%0d exp=%0d", nval, 13); end
    drain_tail("gapped");
  endtask

  task automatic test_sop_err();
    logic [8:0] exp;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, k == 0, 1'b0);
      exp = ctl(k, k >= 3, k == 3, 1'b0, 1'b0);
      chk_n++;
      if (obs !== exp) begin err_n++; $display("FAIL soperr pre k=%0d obs=%b exp=%b", k, obs, exp); end
    end
    // Restart at would-be k=5: emits idx 2, then idx 3, 4, then new idx 0.
    for (int j = 0; j < 16; j++) begin
      step(1'b1, j == 0, 1'b0);
      exp = ctl(j, 1'b1, j == 3, 1'b0, j == 0);
      chk_n++;
      if (obs !== exp) begin err_n++; $display("FAIL soperr post j=%0d obs=%b exp=%b", j, obs, exp); end
    end
    drain_tail("soperr");
  endtask

  task automatic test_rst_mid();
    logic [8:0] exp;
    for (int k = 0; k < 9; k++) step(1'b1, k == 0, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    chk_n++;
    if (obs !== 9'b0) begin err_n++; $display("FAIL rstmid after obs=%b exp=%b", obs, 9'b0); end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      chk_n++;
      if (obs !== 9'b0) begin err_n++; $display("FAIL rstmid nosop i=%0d obs=%b exp=%b", i, obs, 9'b0); end
    end
    for (int k = 0; k < 16; k++) begin
      step(1'b1, k == 0, 1'b0);
      exp = ctl(k, k >= 3, k == 3, 1'b0, 1'b0);
      chk_n++;
      if (obs !== exp) begin err_n++; $display("FAIL rstmid new k=%0d obs=%b exp=%b", k, obs, exp); end
    end
    drain_tail("rstmid");
  endtask

`ifdef FFT_LAST_CTRL_FRAME_CNT_EN
  task automatic test_frame_cnt();
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 48; i++) step(1'b1, (i % 16) == 0, 1'b0);
    for (int i = 0; i < 13; i++) step(1'b0, 1'b0, 1'b0);
    chk_n++;
    if (frame_cnt !== 16'd3) begin err_n++; $display("FAIL frame_cnt obs=%0d exp=%0d", frame_cnt, 3); end
    force dut.frame_cnt_q = 16'hFFFF;
    step(1'b0, 1'b0, 1'b0);
    release dut.frame_cnt_q;
    for (int i = 0; i < 16; i++) step(1'b1, i == 0, 1'b0);
    for (int i = 0; i < 13; i++) step(1'b0, 1'b0, 1'b0);
    chk_n++;
    if (frame_cnt !== 16'd0) begin err_n++; $display("FAIL frame_cnt_wrap obs=%0d exp=%0d", frame_cnt, 0); end
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gapped();
    test_sop_err();
    test_rst_mid();
`ifdef FFT_LAST_CTRL_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("Result: errors=%0d of %0d checks", err_n, chk_n);
    $finish;
  end

endmodule
